// File: rtl/ahb_app_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_app_arbiter
//
// Shares one AHB-Lite master's application interface among NUM_REQ
// requesters. One requester is granted at a time; its INCR burst of
// 1..MAX_BEATS word beats is sequenced onto the master, honouring m_wait.
// Read data, read-valid and error are routed back to the granted requester.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                      undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   req_valid/req_wr      per-requester request and direction (1 = write)
//   req_addr/req_len      per-requester burst start address and beat count
//   req_wdata             per-requester current write-beat data
//   gnt                   registered one-hot grant
//   beat_ack              pulse: address beat accepted, present next wdata
//   rsp_rdata/rsp_valid   read data pass-through to the granted requester
//   rsp_error             pulse: burst aborted on error
//   m_enable..m_data_in   master application inputs
//   m_data_out, m_data_valid, m_error, m_wait   master application outputs
// ----------------------------------------------------------------------------
module ahb_app_arbiter #(
    parameter int  NUM_REQ   = 2,
    parameter int  MAX_BEATS = 16,
    localparam int LEN_W     = $clog2(MAX_BEATS) + 1,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_wr,
    input  logic [NUM_REQ*32-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*32-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       beat_ack,
    output logic [31:0]              rsp_rdata,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [NUM_REQ-1:0]       rsp_error,
    output logic                     m_enable,
    output logic                     m_new_trans,
    output logic                     m_inc,
    output logic                     m_busy,
    output logic                     m_wr,
    output logic [31:0]              m_addr,
    output logic [31:0]              m_data_in,
    input  logic [31:0]              m_data_out,
    input  logic                     m_data_valid,
    input  logic                     m_error,
    input  logic                     m_wait
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t              state_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [IDX_W-1:0]    gidx_r;
    logic [31:0]         addr_r;
    logic [LEN_W-1:0]    rem_r;
    logic                m_enable_r;
    logic                m_new_trans_r;
    logic                m_inc_r;
    logic                m_wr_r;

    logic [IDX_W-1:0]    win_s;
    logic [31:0]         win_addr_s;
    logic [LEN_W-1:0]    win_len_s;
    logic                win_wr_s;
    logic                release_s;
    logic [IDX_W-1:0]    next_ptr_s;
    logic [NUM_REQ-1:0]  beat_ack_s;
    logic [NUM_REQ-1:0]  rsp_valid_s;
    logic [NUM_REQ-1:0]  rsp_error_s;
    logic [31:0]         data_in_s;

    // A length of zero means one beat; anything above MAX_BEATS is clipped.
    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return LEN_W'(1);
        end else if (len > LEN_W'(MAX_BEATS)) begin
            return LEN_W'(MAX_BEATS);
        end else begin
            return len;
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == idx) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

`ifdef ARB_FIXED_PRIO_EN
    // Lowest asserted index wins; scanning downward lets the lowest overwrite.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] vld);
        logic [IDX_W-1:0] win;
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vld[i]) begin
                win = IDX_W'(i);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Fixed priority: winner depends on the request vector only.
    always_comb begin
        win_s = pick_winner(req_valid);
    end
`else
    logic [IDX_W-1:0] rr_ptr_r;

    // First asserted request found when scanning upward from ptr, wrapping.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] vld,
                                                     input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] idx;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && vld[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Round-robin: search starts at the requester after the last one served.
    always_comb begin
        win_s = pick_winner(req_valid, rr_ptr_r);
    end

    // Pointer advances past the served requester whenever a grant is released.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr_r <= '0;
        end else if (release_s) begin
            rr_ptr_r <= next_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Select the winning requester's burst descriptor for latching.
    always_comb begin
        win_addr_s = 32'd0;
        win_len_s  = '0;
        win_wr_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_s) begin
                win_addr_s = req_addr[i*32 +: 32];
                win_len_s  = req_len[i*LEN_W +: LEN_W];
                win_wr_s   = req_wr[i];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Grant release: DRAIN finishing its data phase, or ERR once m_error drops.
    always_comb begin
        release_s  = ((state_r == ST_DRAIN) && !m_error && !m_wait) ||
                     ((state_r == ST_ERR) && !m_error);
        if (gidx_r == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_r + IDX_W'(1);
        end
    end

    // Return-path steering; everything is masked by the registered grant so
    // nothing ever reaches an ungranted requester.
    always_comb begin
        beat_ack_s  = '0;
        rsp_valid_s = '0;
        rsp_error_s = '0;
        data_in_s   = 32'd0;
        if ((state_r == ST_BURST) && !m_wait && !m_error) begin
            beat_ack_s = gnt_r;
        end else begin
            beat_ack_s = '0;
        end
        if (((state_r == ST_BURST) || (state_r == ST_DRAIN)) && m_error) begin
            rsp_error_s = gnt_r;
        end else begin
            rsp_error_s = '0;
        end
        if (m_data_valid) begin
            rsp_valid_s = gnt_r;
        end else begin
            rsp_valid_s = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_r[i]) begin
                data_in_s = req_wdata[i*32 +: 32];
            end else begin
                data_in_s = data_in_s;
            end
        end
    end

    // Burst sequencer: grant, beat counting, address increment, drain, error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r       <= ST_IDLE;
            gnt_r         <= '0;
            gidx_r        <= '0;
            addr_r        <= 32'd0;
            rem_r         <= '0;
            m_enable_r    <= 1'b0;
            m_new_trans_r <= 1'b0;
            m_inc_r       <= 1'b0;
            m_wr_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        gidx_r        <= win_s;
                        gnt_r         <= to_onehot(win_s);
                        addr_r        <= win_addr_s;
                        rem_r         <= clip_len(win_len_s);
                        m_enable_r    <= 1'b1;
                        m_new_trans_r <= 1'b1;
                        // m_inc reflects the burst length, constant for the burst.
                        m_inc_r       <= (clip_len(win_len_s) > LEN_W'(1));
                        m_wr_r        <= win_wr_s;
                        state_r       <= ST_BURST;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (m_error) begin
                        rem_r         <= '0;
                        m_enable_r    <= 1'b0;
                        m_new_trans_r <= 1'b0;
                        m_inc_r       <= 1'b0;
                        m_wr_r        <= 1'b0;
                        state_r       <= ST_ERR;
                    end else if (!m_wait) begin
                        addr_r        <= addr_r + 32'd4;
                        rem_r         <= rem_r - LEN_W'(1);
                        m_new_trans_r <= 1'b0;
                        if (rem_r == LEN_W'(1)) begin
                            m_enable_r <= 1'b0;
                            m_inc_r    <= 1'b0;
                            m_wr_r     <= 1'b0;
                            state_r    <= ST_DRAIN;
                        end else begin
                            state_r    <= ST_BURST;
                        end
                    end else begin
                        state_r       <= ST_BURST;
                    end
                end
                ST_DRAIN: begin
                    if (m_error) begin
                        state_r <= ST_ERR;
                    end else if (!m_wait) begin
                        gnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_ERR: begin
                    if (!m_error) begin
                        gnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    gnt_r         <= '0;
                    m_enable_r    <= 1'b0;
                    m_new_trans_r <= 1'b0;
                    m_inc_r       <= 1'b0;
                    m_wr_r        <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_r;
    assign beat_ack    = beat_ack_s;
    assign rsp_valid   = rsp_valid_s;
    assign rsp_error   = rsp_error_s;
    assign rsp_rdata   = (|gnt_r) ? m_data_out : 32'd0;
    assign m_enable    = m_enable_r;
    assign m_new_trans = m_new_trans_r;
    assign m_inc       = m_inc_r;
    assign m_busy      = 1'b0;
    assign m_wr        = m_wr_r;
    assign m_addr      = addr_r;
    assign m_data_in   = data_in_s;

endmodule

// File: tb/tb_ahb_app_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_app_arbiter
//
// Directed scenarios followed by randomized bursts. A transaction-level model
// (round-robin pointer, effective length, start address) predicts the winner,
// every beat address and the grant release; the master side (wait, error,
// read data) is driven from the bench.
// ----------------------------------------------------------------------------
module tb_ahb_app_arbiter;

    localparam int NR = 3;
    localparam int MB = 16;
    localparam int LW = $clog2(MB) + 1;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [NR-1:0]     req_valid, req_wr;
    logic [NR*32-1:0]  req_addr, req_wdata;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     gnt, beat_ack, rsp_valid, rsp_error;
    logic [31:0]       rsp_rdata, m_addr, m_data_in, m_data_out;
    logic              m_enable, m_new_trans, m_inc, m_busy, m_wr;
    logic              m_data_valid, m_error, m_wait;

    int n_cmp = 0;
    int n_err = 0;
    int rr_m  = 0;

    ahb_app_arbiter #(.NUM_REQ(NR), .MAX_BEATS(MB)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .gnt(gnt), .beat_ack(beat_ack), .rsp_rdata(rsp_rdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error),
        .m_enable(m_enable), .m_new_trans(m_new_trans), .m_inc(m_inc),
        .m_busy(m_busy), .m_wr(m_wr), .m_addr(m_addr), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_data_valid(m_data_valid),
        .m_error(m_error), .m_wait(m_wait)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: first valid requester scanning from the round-robin pointer.
    function automatic int pick(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[(rr_m + i) % NR]) return (rr_m + i) % NR;
        end
        return 0;
    endfunction

    function automatic int eff_len(input int l);
        return (l == 0) ? 1 : ((l > MB) ? MB : l);
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        m_wait = 1'b0; m_error = 1'b0; m_data_valid = 1'b0; m_data_out = 32'd0;
    endtask

    task automatic set_one(input int i, input logic wr, input logic [31:0] a, input int len);
        req_valid[i] = 1'b1;
        req_wr[i] = wr;
        req_addr[i*32 +: 32] = a;
        req_len[i*LW +: LW] = LW'(len);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_ctl"}, {27'd0, m_enable, m_new_trans, m_inc, m_busy, m_wr}, 32'd0);
        chk({tag, "_addr"}, m_addr, 32'd0);
        chk({tag, "_din"}, m_data_in, 32'd0);
        chk({tag, "_ack"}, 32'(beat_ack), 32'd0);
        chk({tag, "_rsp"}, {26'd0, rsp_valid, rsp_error}, 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    endtask

    // Called in an IDLE cycle with requests already driven. Runs one grant
    // through to its release, checking every cycle against the model.
    task automatic do_burst(input int idx, input logic [31:0] a0, input int beats,
                            input logic wr, input int wait_pct, input int wbeat,
                            input int wcnt, input int ebeat, input bit scram);
        logic [NR-1:0] oh;
        int k, cyc, acks, wleft, h;
        bit errd;
        oh = '0;
        oh[idx] = 1'b1;
        k = 0; cyc = 0; acks = 0; wleft = wcnt; errd = 1'b0;
        #1;
        chk("gnt_latency", 32'(gnt), 32'd0);
        while (k < beats && !errd && cyc < 300) begin
            step();
            cyc++;
            for (int i = 0; i < NR; i++) req_wdata[i*32 +: 32] = $urandom;
            if (scram) begin
                req_valid = NR'($urandom); req_wr = NR'($urandom);
                for (int i = 0; i < NR; i++) begin
                    req_addr[i*32 +: 32] = $urandom;
                    req_len[i*LW +: LW] = LW'($urandom);
                end
            end
            m_error = (k == ebeat);
            if (k == wbeat && wleft > 0) begin
                m_wait = 1'b1;
                wleft--;
            end else begin
                m_wait = ($urandom_range(99) < wait_pct);
            end
            m_data_valid = $urandom_range(1);
            m_data_out = $urandom;
            #1;
            chk("b_gnt", 32'(gnt), 32'(oh));
            chk("b_enable", 32'(m_enable), 32'd1);
            chk("b_addr", m_addr, a0 + 32'(4 * k));
            chk("b_new_trans", 32'(m_new_trans), 32'(k == 0));
            chk("b_inc", 32'(m_inc), 32'(beats > 1));
            chk("b_wr", 32'(m_wr), 32'(wr));
            chk("b_busy", 32'(m_busy), 32'd0);
            chk("b_data_in", m_data_in, req_wdata[idx*32 +: 32]);
            chk("b_ack", 32'(beat_ack), (!m_wait && !m_error) ? 32'(oh) : 32'd0);
            chk("b_rsp_error", 32'(rsp_error), m_error ? 32'(oh) : 32'd0);
            chk("b_rsp_valid", 32'(rsp_valid), m_data_valid ? 32'(oh) : 32'd0);
            chk("b_rdata", rsp_rdata, m_data_out);
            if (beat_ack == oh) acks++;
            if (m_error) errd = 1'b1;
            else if (!m_wait) k++;
        end
        if (cyc >= 300) chk("burst_timeout", 32'(cyc), 32'd0);
        chk("ack_count", 32'(acks), errd ? 32'(ebeat) : 32'(beats));
        if (errd) begin
            h = $urandom_range(2);
            for (int c = 0; c < 10; c++) begin
                step();
                m_error = (h > 0);
                if (h > 0) h--;
                m_wait = $urandom_range(1);
                #1;
                chk("e_gnt", 32'(gnt), 32'(oh));
                chk("e_enable", 32'(m_enable), 32'd0);
                chk("e_ack", 32'(beat_ack), 32'd0);
                chk("e_rsp_error", 32'(rsp_error), 32'd0);
                if (!m_error) break;
            end
        end else begin
            for (int c = 0; c < 10; c++) begin
                step();
                m_error = 1'b0;
                m_wait = (c < 5) ? ($urandom_range(99) < wait_pct) : 1'b0;
                #1;
                chk("d_gnt", 32'(gnt), 32'(oh));
                chk("d_enable", 32'(m_enable), 32'd0);
                chk("d_ack", 32'(beat_ack), 32'd0);
                chk("d_addr", m_addr, a0 + 32'(4 * beats));
                chk("d_data_in", m_data_in, req_wdata[idx*32 +: 32]);
                if (!m_wait) break;
            end
        end
        step();
        m_error = 1'b0; m_wait = 1'b0;
        m_data_valid = 1'b1; m_data_out = $urandom;
        #1;
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_enable", 32'(m_enable), 32'd0);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rel_rdata", rsp_rdata, 32'd0);
        rr_m = (idx + 1) % NR;
    endtask

    initial begin
        logic [31:0] a_arr [NR];
        int          l_arr [NR];
        logic        w_arr [NR];
        logic [NR-1:0] mask;
        logic [31:0] tmp;
        int w, eb;

        // Reset state
        clear_inputs();
        HRESETn = 1'b0;
        req_wdata = {NR{32'hA5A5_5A5A}};
        step(); step();
        check_all_zero("reset");
        HRESETn = 1'b1;
        clear_inputs();
        rr_m = 0;

        // Two simultaneous requesters served in turn, then req0 again.
        set_one(0, 1'b1, 32'h300, 2);
        set_one(1, 1'b0, 32'h400, 1);
        w = pick(req_valid);
        do_burst(w, w == 0 ? 32'h300 : 32'h400, w == 0 ? 2 : 1, w == 0, 0, -1, 0, -1, 1'b0);
        w = pick(req_valid);
        do_burst(w, w == 0 ? 32'h300 : 32'h400, w == 0 ? 2 : 1, w == 0, 0, -1, 0, -1, 1'b0);
        w = pick(req_valid);
        do_burst(w, w == 0 ? 32'h300 : 32'h400, w == 0 ? 2 : 1, w == 0, 0, -1, 0, -1, 1'b0);

        // Single write burst of four, no waits.
        clear_inputs();
        set_one(0, 1'b1, 32'h100, 4);
        do_burst(0, 32'h100, 4, 1'b1, 0, -1, 0, -1, 1'b0);

        // Read of two beats with three wait cycles on the second beat.
        clear_inputs();
        set_one(1, 1'b0, 32'h200, 2);
        do_burst(1, 32'h200, 2, 1'b0, 0, 1, 3, -1, 1'b0);

        // Error on the second beat of an eight-beat write.
        clear_inputs();
        set_one(0, 1'b1, 32'h500, 8);
        do_burst(0, 32'h500, 8, 1'b1, 0, -1, 0, 1, 1'b0);

        // Length zero -> one beat; length 31 -> clipped, with address wrap.
        clear_inputs();
        set_one(2, 1'b0, 32'h700, 0);
        do_burst(2, 32'h700, eff_len(0), 1'b0, 20, -1, 0, -1, 1'b0);
        clear_inputs();
        set_one(0, 1'b1, 32'hFFFF_FFF8, 31);
        do_burst(0, 32'hFFFF_FFF8, eff_len(31), 1'b1, 20, -1, 0, -1, 1'b0);

        // Reset mid-burst; afterwards arbitration restarts from requester 0.
        clear_inputs();
        set_one(1, 1'b1, 32'h600, 8);
        step();
        step();
        step();
        #2;
        HRESETn = 1'b0;
        m_data_valid = 1'b1; m_error = 1'b1; m_data_out = 32'hDEAD_BEEF;
        req_wdata = {NR{32'h1234_5678}};
        #1;
        check_all_zero("async_rst");
        step();
        clear_inputs();
        HRESETn = 1'b1;
        rr_m = 0;
        set_one(0, 1'b0, 32'h800, 2);
        set_one(1, 1'b0, 32'h900, 2);
        w = pick(req_valid);
        do_burst(w, w == 0 ? 32'h800 : 32'h900, 2, 1'b0, 0, -1, 0, -1, 1'b0);

        // Randomized bursts with request lines scrambled while granted.
        for (int ep = 0; ep < 40; ep++) begin
            clear_inputs();
            mask = NR'($urandom_range((1 << NR) - 1, 1));
            for (int i = 0; i < NR; i++) begin
                tmp = $urandom;
                tmp[1:0] = 2'b00;
                a_arr[i] = tmp;
                l_arr[i] = $urandom_range(31);
                w_arr[i] = $urandom_range(1);
                if (mask[i]) set_one(i, w_arr[i], a_arr[i], l_arr[i]);
            end
            w = pick(req_valid);
            eb = ($urandom_range(7) == 0) ? $urandom_range(eff_len(l_arr[w]) - 1) : -1;
            do_burst(w, a_arr[w], eff_len(l_arr[w]), w_arr[w], 30, -1, 0, eb, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
